// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer for the RV64 M extension.
//
// Runs one op at a time. Multiplies use an add-shift loop that consumes one
// multiplier bit per cycle. Divides use a restoring loop that produces one
// quotient bit per cycle. W ops always run 32 iterations and return the low
// 32 bits sign-extended. Divide-by-zero, signed overflow and malformed ops
// skip the loop and finish on the accept edge.
//
// Ports
//   clk        clock, all state on posedge
//   reset      asynchronous active-low reset
//   in_valid   op presented by decode
//   in_ready   high only while idle; accept = in_valid & in_ready & ~flush
//   op         one-hot {remu,rem,divu,div,mul}
//   word       W variant select
//   src1       dividend / multiplicand
//   src2       divisor / multiplier
//   flush      abort any op; no result is produced
//   out_valid  result available, held until out_ready
//   out_ready  consumer takes result on out_valid & out_ready
//   result     final value, stable while out_valid
//   busy       sequencer not idle
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  // Working registers
  logic [CW-1:0]   cnt;
  logic            is_mul, is_rem, is_word, neg_q, neg_r;
  logic [XLEN-1:0] dvs;   // divisor magnitude, or multiplicand (shifts left)
  logic [XLEN-1:0] dvd;   // dividend shifting out / quotient shifting in, or multiplier
  logic [XLEN-1:0] acc;   // product accumulator
  logic [XLEN-1:0] prem;  // partial remainder (always < divisor)
  logic [XLEN-1:0] res_q;

  // Low 32 bits sign-extended for W ops.
  function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand prep and special-case detection
  logic            ext_signed, op_signed, one_hot, a_neg, b_neg;
  logic            div_zero, ovf, special, accept;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_val;

  always_comb begin
    // Only divuw/remuw zero-extend; mulw bits are the same either way.
    ext_signed = ~(op[2] | op[4]);
    op_signed  = op[1] | op[3];
    a_ext      = src1;
    b_ext      = src2;
    min_val    = {1'b1, {(XLEN-1){1'b0}}};
    if (word) begin
      a_ext   = {{(XLEN-32){ext_signed & src1[31]}}, src1[31:0]};
      b_ext   = {{(XLEN-32){ext_signed & src2[31]}}, src2[31:0]};
      min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end
    a_neg    = op_signed & a_ext[XLEN-1];
    b_neg    = op_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    one_hot  = (op != 5'd0) && ((op & (op - 5'd1)) == 5'd0);
    div_zero = ~op[0] & (b_ext == '0);
    ovf      = op_signed & (a_ext == min_val) & (b_ext == '1);
    special  = ~one_hot | div_zero | ovf;
    spec_val = '0;
    if (one_hot) begin
      if (div_zero)
        spec_val = (op[1] | op[2]) ? '1 : a_ext;
      else if (ovf)
        spec_val = op[1] ? a_ext : '0;
    end
  end

  assign accept = in_valid & in_ready & ~flush;

  // One iteration of either datapath, plus the final sign/width fixup
  logic [XLEN:0]   shifted, trial;
  logic            qbit;
  logic [XLEN-1:0] prem_nx, quo_nx, acc_nx, rem_fix, quo_fix, fin, fin_val;

  always_comb begin
    shifted = {prem, dvd[XLEN-1]};
    trial   = shifted - {1'b0, dvs};
    qbit    = ~trial[XLEN];            // no borrow -> divisor fits
    prem_nx = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nx  = {dvd[XLEN-2:0], qbit};
    acc_nx  = dvd[0] ? acc + dvs : acc;
    rem_fix = neg_r ? -prem_nx : prem_nx;
    quo_fix = neg_q ? -quo_nx : quo_nx;
    fin     = is_mul ? acc_nx : (is_rem ? rem_fix : quo_fix);
    fin_val = fix_w(is_word, fin);
  end

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nx = special ? DONE : CALC;
        CALC: if (cnt == '0) state_nx = DONE;
        DONE: if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      is_mul  <= 1'b0;
      is_rem  <= 1'b0;
      is_word <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dvs     <= '0;
      dvd     <= '0;
      acc     <= '0;
      prem    <= '0;
      res_q   <= '0;
    end else if (accept) begin
      cnt     <= word ? CW'(31) : CW'(XLEN-1);
      is_mul  <= op[0];
      is_rem  <= op[3] | op[4];
      is_word <= word;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      acc     <= '0;
      prem    <= '0;
      dvs     <= op[0] ? a_ext : b_mag;
      // W divides park the 32-bit dividend at the top so 32 shifts drain it.
      if (op[0])     dvd <= b_ext;
      else if (word) dvd <= {a_mag[31:0], {(XLEN-32){1'b0}}};
      else           dvd <= a_mag;
      if (special) res_q <= fix_w(word, spec_val);
    end else if (state == CALC && !flush) begin
      cnt <= cnt - CW'(1);
      if (is_mul) begin
        acc <= acc_nx;
        dvs <= dvs << 1;
        dvd <= dvd >> 1;
      end else begin
        prem <= prem_nx;
        dvd  <= quo_nx;
      end
      if (cnt == '0) res_q <= fin_val;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural reference model and a
// per-cycle compare process against a queue of expected results.
module tb_mdu_seq;

  localparam logic [4:0] MUL  = 5'b00001;
  localparam logic [4:0] DIV  = 5'b00010;
  localparam logic [4:0] DIVU = 5'b00100;
  localparam logic [4:0] REM  = 5'b01000;
  localparam logic [4:0] REMU = 5'b10000;

  logic        clk, reset, in_valid, in_ready, word, flush, out_valid, out_ready, busy;
  logic [4:0]  op;
  logic [63:0] src1, src2, result;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mdu_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain RISC-V M-extension arithmetic.
  function automatic logic [63:0] model(input logic [4:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    logic [63:0] r64;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32; sa = a; sb = b;
    r32 = '0; r64 = '0;
    if ($countones(o) != 1) return 64'd0;
    if (w) begin
      if (o[0]) r32 = a32 * b32;
      else if (o[1]) begin
        if (b32 == 0) r32 = '1;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
        else r32 = sa32 / sb32;
      end else if (o[2]) r32 = (b32 == 0) ? '1 : a32 / b32;
      else if (o[3]) begin
        if (b32 == 0) r32 = a32;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
        else r32 = sa32 % sb32;
      end else r32 = (b32 == 0) ? a32 : a32 % b32;
      return {{32{r32[31]}}, r32};
    end
    if (o[0]) r64 = a * b;
    else if (o[1]) begin
      if (b == 0) r64 = '1;
      else if (a == 64'h8000_0000_0000_0000 && b == '1) r64 = a;
      else r64 = sa / sb;
    end else if (o[2]) r64 = (b == 0) ? '1 : a / b;
    else if (o[3]) begin
      if (b == 0) r64 = a;
      else if (a == 64'h8000_0000_0000_0000 && b == '1) r64 = '0;
      else r64 = sa % sb;
    end else r64 = (b == 0) ? a : a % b;
    return r64;
  endfunction

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      check("in_ready_vs_busy", {63'd0, in_ready}, {63'd0, ~busy});
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        else begin
          check("result_vs_model", result, exp_q[0]);
          if (out_ready || flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Issue one op, check latency, optionally hold backpressure, then retire it.
  // Entered and left at posedge+2.
  task automatic do_op(input string nm, input logic [4:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] lit, input int lat, input int hold);
    int k;
    check({nm, "_model"}, model(o, w, a, b), lit);
    k = 0;
    while (!in_ready && k < 200) begin @(posedge clk); #2; k++; end
    check({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    exp_q.push_back(model(o, w, a, b));
    @(posedge clk); #2;
    in_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 200);
    check({nm, "_latency"}, 64'(k), 64'(lat));
    check({nm, "_result"}, result, lit);
    @(posedge clk); #2;
    for (int i = 0; i < hold; i++) begin
      check({nm, "_held_valid"}, {63'd0, out_valid}, 64'd1);
      check({nm, "_held_result"}, result, lit);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    check({nm, "_retired"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    reset = 1'b0; in_valid = 1'b0; op = '0; word = 1'b0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b1;
    @(posedge clk); #2;

    // Directed vectors
    do_op("t1_mul",   MUL,  0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    do_op("t2_divw",  DIV,  1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("t3_divu0", DIVU, 0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("t3_remu0", REMU, 0, 64'h1234, 64'h0, 64'h1234, 1, 0);
    do_op("t4_rem",   REM,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("t4_div",   DIV,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    do_op("rem_ovf",  REM,  0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0);
    do_op("div_ovf",  DIV,  0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    do_op("div_min2", DIV,  0, 64'h8000_0000_0000_0000, 64'h2, 64'hC000_0000_0000_0000, 65, 0);
    do_op("rem0",     REM,  0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0);
    do_op("remu_big", REMU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65, 0);
    do_op("divu_big", DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("mul_m1sq", MUL,  0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65, 0);
    do_op("mulw",     MUL,  1, 64'h1234_5678_7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    do_op("divuw",    DIVU, 1, 64'h0000_0000_FFFF_FFFF, 64'hAAAA_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    do_op("divw_neg", DIV,  1, 64'h0000_0000_FFFF_FF9C, 64'h7, 64'hFFFF_FFFF_FFFF_FFF2, 33, 0);
    do_op("remw_neg", REM,  1, 64'h0000_0000_FFFF_FF9C, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    do_op("remuw0",   REMU, 1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, 0);
    do_op("op_multi", 5'b00011, 0, 64'h55, 64'h3, 64'h0, 1, 0);
    do_op("op_zero",  5'b00000, 0, 64'h55, 64'h3, 64'h0, 1, 0);

    // T5: backpressure for 10 cycles
    do_op("t5_hold",  DIVU, 0, 64'd100, 64'd7, 64'd14, 65, 10);

    // T5: flush mid-CALC
    op = MUL; word = 1'b0; src1 = 64'h3; src2 = 64'h5; in_valid = 1'b1;
    exp_q.push_back(model(MUL, 1'b0, 64'h3, 64'h5));
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    check("flush_calc_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    flush = 1'b0;
    check("flush_calc_busy", {63'd0, busy}, 64'd0);
    check("flush_calc_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    repeat (70) begin @(posedge clk); #2; if (out_valid) seen++; end
    check("flush_calc_no_result", 64'(seen), 64'd0);

    // flush with in_valid in IDLE: no accept
    op = DIVU; src1 = 64'h9; src2 = 64'h0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {63'd0, busy}, 64'd0);
    check("flush_idle_out_valid", {63'd0, out_valid}, 64'd0);

    // flush in DONE together with out_ready: result discarded
    op = REMU; src1 = 64'h77; src2 = 64'h0; in_valid = 1'b1;
    exp_q.push_back(model(REMU, 1'b0, 64'h77, 64'h0));
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_done_busy", {63'd0, busy}, 64'd0);

    // T6: asynchronous reset in CALC at cycle 20
    op = MUL; word = 1'b0; src1 = 64'h11; src2 = 64'h13; in_valid = 1'b1;
    exp_q.push_back(model(MUL, 1'b0, 64'h11, 64'h13));
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #2; end
    check("t6_busy_before", {63'd0, busy}, 64'd1);
    check("t6_result_before", result, 64'h77);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);
    check("t6_result", result, 64'd0);
    repeat (2) @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    do_op("t6_remuw", REMU, 1, 64'hFFFF_FFFF_0000_000A, 64'h3, 64'h1, 33, 0);

    repeat (3) begin @(posedge clk); #2; end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
